// File: rtl/ctrl_decode_stage.sv
// Registered RV32I control decoder between IF/ID and EX, with handshake, flush and load-use stall.
// Define CTRL_DECODE_MEXT_EN to accept M-extension R-type ops and add the mext_o output.
module ctrl_decode_stage #(
    parameter int ALUCTRL_W = 4,
    parameter int IMMSRC_W  = 3,
    parameter int RESSRC_W  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [31:0]          instr_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    input  logic                 out_ready_i,
    output logic                 out_valid_o,
    output logic                 reg_write_o,
    output logic                 mem_write_o,
    output logic                 alu_src_o,
    output logic                 branch_o,
    output logic                 jump_o,
    output logic                 jalr_o,
    output logic                 a_src_pc_o,
    output logic [RESSRC_W-1:0]  result_src_o,
    output logic [IMMSRC_W-1:0]  imm_src_o,
    output logic [ALUCTRL_W-1:0] alu_ctrl_o,
    output logic [4:0]           rd_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
`ifdef CTRL_DECODE_MEXT_EN
    output logic                 mext_o,
`endif
    output logic                 illegal_o
);

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_write;
        logic                 alu_src;
        logic                 branch;
        logic                 jump;
        logic                 jalr;
        logic                 a_src_pc;
        logic [RESSRC_W-1:0]  result_src;
        logic [IMMSRC_W-1:0]  imm_src;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
`ifdef CTRL_DECODE_MEXT_EN
        logic                 mext;
`endif
        logic                 illegal;
    } ctrl_t;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alt selects sub (funct3 000) or sra (funct3 101)
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_of = ALU_SLL;
            3'b010:  alu_of = ALU_SLT;
            3'b011:  alu_of = ALU_SLTU;
            3'b100:  alu_of = ALU_XOR;
            3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu4;
    logic       ill;
    ctrl_t      dec;
    ctrl_t      ctrl_q, ctrl_d;
    logic       valid_q, valid_d;
    logic       adv, haz;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        dec  = '0;
        alu4 = ALU_ADD;
        ill  = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec.reg_write = 1'b1;
                case (funct7)
                    F7_ZERO: alu4 = alu_of(funct3, 1'b0);
                    F7_ALT: begin
                        alu4 = alu_of(funct3, 1'b1);
                        ill  = (funct3 != 3'b000) && (funct3 != 3'b101);
                    end
`ifdef CTRL_DECODE_MEXT_EN
                    7'b0000001: begin
                        alu4     = {1'b1, funct3};
                        dec.mext = 1'b1;
                    end
`endif
                    default: ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                alu4 = alu_of(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
                // only the shift-immediates carry a funct7 field
                if (funct3 == 3'b001 && funct7 != F7_ZERO)
                    ill = 1'b1;
                if (funct3 == 3'b101 && funct7 != F7_ZERO && funct7 != F7_ALT)
                    ill = 1'b1;
            end
            7'b0000011: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RESSRC_W'(2'b01);
            end
            7'b0100011: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMMSRC_W'(3'b001);
            end
            7'b1100011: begin
                dec.branch  = 1'b1;
                dec.imm_src = IMMSRC_W'(3'b010);
                alu4        = ALU_SUB;
            end
            7'b1101111: begin
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.imm_src    = IMMSRC_W'(3'b100);
                dec.result_src = RESSRC_W'(2'b10);
            end
            7'b1100111: begin
                dec.jalr       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RESSRC_W'(2'b10);
                ill            = (funct3 != 3'b000);
            end
            7'b0110111: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMMSRC_W'(3'b011);
                alu4          = ALU_PASSB;
            end
            7'b0010111: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.a_src_pc  = 1'b1;
                dec.imm_src   = IMMSRC_W'(3'b011);
            end
            default: ill = 1'b1;
        endcase
        dec.alu_ctrl = ALUCTRL_W'(alu4);
        // an illegal instruction travels as a side-effect-free marker
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.rd  = instr_i[11:7];
        dec.rs1 = instr_i[19:15];
        dec.rs2 = instr_i[24:20];
    end

    assign adv = out_ready_i | ~valid_q;
    assign haz = valid_q && (ctrl_q.result_src == RESSRC_W'(2'b01)) && (ctrl_q.rd != 5'd0)
              && ((ctrl_q.rd == instr_i[19:15]) || (ctrl_q.rd == instr_i[24:20])) && in_valid_i;
    assign in_ready_o = adv & ~haz;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        if (flush_i || (adv && (haz || !in_valid_i))) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (adv) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid_o  = valid_q;
    assign reg_write_o  = ctrl_q.reg_write;
    assign mem_write_o  = ctrl_q.mem_write;
    assign alu_src_o    = ctrl_q.alu_src;
    assign branch_o     = ctrl_q.branch;
    assign jump_o       = ctrl_q.jump;
    assign jalr_o       = ctrl_q.jalr;
    assign a_src_pc_o   = ctrl_q.a_src_pc;
    assign result_src_o = ctrl_q.result_src;
    assign imm_src_o    = ctrl_q.imm_src;
    assign alu_ctrl_o   = ctrl_q.alu_ctrl;
    assign rd_o         = ctrl_q.rd;
    assign rs1_o        = ctrl_q.rs1;
    assign rs2_o        = ctrl_q.rs2;
    assign illegal_o    = ctrl_q.illegal;
`ifdef CTRL_DECODE_MEXT_EN
    assign mext_o       = ctrl_q.mext;
`endif

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: handshake, load-use stall, backpressure, flush, decode table.
module tb_ctrl_decode_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] instr_i = 32'h0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        flush_i = 1'b0;
    logic        out_ready_i = 1'b1;
    logic        out_valid_o;
    logic        reg_write_o, mem_write_o, alu_src_o, branch_o, jump_o, jalr_o, a_src_pc_o;
    logic [1:0]  result_src_o;
    logic [2:0]  imm_src_o;
    logic [3:0]  alu_ctrl_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic        illegal_o;
`ifdef CTRL_DECODE_MEXT_EN
    logic        mext_o;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    ctrl_decode_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .flush_i(flush_i), .out_ready_i(out_ready_i),
        .out_valid_o(out_valid_o), .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
        .alu_src_o(alu_src_o), .branch_o(branch_o), .jump_o(jump_o), .jalr_o(jalr_o),
        .a_src_pc_o(a_src_pc_o), .result_src_o(result_src_o), .imm_src_o(imm_src_o),
        .alu_ctrl_o(alu_ctrl_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
`ifdef CTRL_DECODE_MEXT_EN
        .mext_o(mext_o),
`endif
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // {rw, mw, alu_src, branch, jump, jalr, a_src_pc, result_src[2], imm_src[3], alu_ctrl[4], illegal}
    logic [16:0] ctrl_vec;
    assign ctrl_vec = {reg_write_o, mem_write_o, alu_src_o, branch_o, jump_o, jalr_o, a_src_pc_o,
                       result_src_o, imm_src_o, alu_ctrl_o, illegal_o};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // drive at negedge, let one rising edge pass, return at the following negedge
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    localparam int NV = 15;
    logic [31:0] vec_instr [NV];
    logic [16:0] vec_exp   [NV];

    initial begin
        vec_instr[0]  = 32'h0020A223; vec_exp[0]  = 17'b0_1_1_0_0_0_0_00_001_0000_0; // sw
        vec_instr[1]  = 32'h00208063; vec_exp[1]  = 17'b0_0_0_1_0_0_0_00_010_0001_0; // beq
        vec_instr[2]  = 32'h000000EF; vec_exp[2]  = 17'b1_0_0_0_1_0_0_10_100_0000_0; // jal
        vec_instr[3]  = 32'h000100E7; vec_exp[3]  = 17'b1_0_1_0_0_1_0_10_000_0000_0; // jalr
        vec_instr[4]  = 32'h000110E7; vec_exp[4]  = 17'b0_0_0_0_0_0_0_00_000_0000_1; // jalr f3=001
        vec_instr[5]  = 32'h123452B7; vec_exp[5]  = 17'b1_0_1_0_0_0_0_00_011_1010_0; // lui
        vec_instr[6]  = 32'h00001297; vec_exp[6]  = 17'b1_0_1_0_0_0_1_00_011_0000_0; // auipc
        vec_instr[7]  = 32'h4032D293; vec_exp[7]  = 17'b1_0_1_0_0_0_0_00_000_1001_0; // srai
        vec_instr[8]  = 32'h40329293; vec_exp[8]  = 17'b0_0_0_0_0_0_0_00_000_0000_1; // slli bad f7
        vec_instr[9]  = 32'h007332B3; vec_exp[9]  = 17'b1_0_0_0_0_0_0_00_000_0110_0; // sltu
        vec_instr[10] = 32'h407342B3; vec_exp[10] = 17'b0_0_0_0_0_0_0_00_000_0000_1; // xor with f7 alt
`ifdef CTRL_DECODE_MEXT_EN
        vec_instr[11] = 32'h027302B3; vec_exp[11] = 17'b1_0_0_0_0_0_0_00_000_1000_0; // mul
`else
        vec_instr[11] = 32'h027302B3; vec_exp[11] = 17'b0_0_0_0_0_0_0_00_000_0000_1; // mul w/o M
`endif
        vec_instr[12] = 32'hFFF34293; vec_exp[12] = 17'b1_0_1_0_0_0_0_00_000_0100_0; // xori
        vec_instr[13] = 32'h407352B3; vec_exp[13] = 17'b1_0_0_0_0_0_0_00_000_1001_0; // sra
        vec_instr[14] = 32'h007352B3; vec_exp[14] = 17'b1_0_0_0_0_0_0_00_000_1000_0; // srl
    end

    initial begin
        #3;
        check("reset out_valid", {31'b0, out_valid_o}, 32'd0);
        check("reset ctrl", {15'b0, ctrl_vec}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1 check("idle in_ready", {31'b0, in_ready_o}, 32'd1);

        // sub a0,a0,a1
        instr_i = 32'h40B50533; in_valid_i = 1'b1;
        step();
        check("sub out_valid", {31'b0, out_valid_o}, 32'd1);
        check("sub ctrl", {15'b0, ctrl_vec}, {15'b0, 17'b1_0_0_0_0_0_0_00_000_0001_0});
        check("sub regs", {17'b0, rd_o, rs1_o, rs2_o}, {17'b0, 5'd10, 5'd10, 5'd11});

        // lw x5,0(x1) then add x6,x5,x2
        instr_i = 32'h0000A283;
        step();
        check("lw ctrl", {15'b0, ctrl_vec}, {15'b0, 17'b1_0_1_0_0_0_0_01_000_0000_0});
        check("lw rd", {27'b0, rd_o}, 32'd5);
        instr_i = 32'h00228333;
        #1 check("hazard in_ready", {31'b0, in_ready_o}, 32'd0);
        @(negedge clk_i);
        check("bubble out_valid", {31'b0, out_valid_o}, 32'd0);
        check("bubble in_ready", {31'b0, in_ready_o}, 32'd1);
        step();
        check("add after stall valid", {31'b0, out_valid_o}, 32'd1);
        check("add after stall regs", {17'b0, rd_o, rs1_o, rs2_o}, {17'b0, 5'd6, 5'd5, 5'd2});

        // load to x0 never stalls
        instr_i = 32'h0000A003;
        step();
        instr_i = 32'h00200333;
        #1 check("rd0 no hazard", {31'b0, in_ready_o}, 32'd1);
        @(negedge clk_i);
        check("rd0 add issued", {26'b0, out_valid_o, rd_o}, {26'b0, 1'b1, 5'd6});

        // backpressure with addi a1,a1,12 waiting
        instr_i = 32'h00C58593; out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp in_ready", {31'b0, in_ready_o}, 32'd0);
            step();
            check("bp hold", {21'b0, out_valid_o, alu_src_o, rd_o, rs1_o}, {21'b0, 1'b1, 1'b0, 5'd6, 5'd0});
        end
        out_ready_i = 1'b1;
        #1 check("bp release in_ready", {31'b0, in_ready_o}, 32'd1);
        @(negedge clk_i);
        check("addi ctrl", {15'b0, ctrl_vec}, {15'b0, 17'b1_0_1_0_0_0_0_00_000_0000_0});
        check("addi rd", {27'b0, rd_o}, 32'd11);

        // flush with a valid instr presented and a valid output
        instr_i = 32'h40B50533; flush_i = 1'b1;
        step();
        check("flush out_valid", {31'b0, out_valid_o}, 32'd0);
        flush_i = 1'b0; in_valid_i = 1'b0;
        step();
        check("flush not issued", {31'b0, out_valid_o}, 32'd0);

        // unlisted opcode
        instr_i = 32'h0000007F; in_valid_i = 1'b1;
        step();
        check("illegal out_valid", {31'b0, out_valid_o}, 32'd1);
        check("illegal ctrl", {15'b0, ctrl_vec}, {15'b0, 17'b0_0_0_0_0_0_0_00_000_0000_1});

        for (int i = 0; i < NV; i++) begin
            instr_i = vec_instr[i];
            step();
            check($sformatf("vec%0d 0x%08h", i, vec_instr[i]), {15'b0, ctrl_vec}, {15'b0, vec_exp[i]});
        end

        // asynchronous reset while holding a valid output
        #2 rst_ni = 1'b0;
        #1 check("async reset valid", {31'b0, out_valid_o}, 32'd0);
        check("async reset ctrl", {2'b0, ctrl_vec, rd_o, rs1_o, rs2_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered RV32I control decoder: decodes opcode/funct3/funct7 of the instruction in ID and registers all control fields into the ID/EX boundary.
- Adds over the combinational decoder: full ALU op set (shifts, xor, sltu, lui/auipc/jal/jalr), illegal-instruction flagging, valid/ready handshake, flush and load-use stall detection.
- Sits between the IF/ID register and the execute stage.

Parameters:
- ALUCTRL_W, 4, width of alu_ctrl (minimum 4).
- IMMSRC_W, 3, width of imm_src (minimum 3).
- RESSRC_W, 2, width of result_src (minimum 2).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-low reset
- instr  in  32  instruction from IF/ID
- in_valid  in  1  instr valid
- in_ready  out  1  stage accepts instr this cycle
- flush  in  1  synchronous kill of the registered instruction and any instr presented this cycle
- out_ready  in  1  EX can accept
- out_valid  out  1  registered control valid
- reg_write, mem_write, alu_src, branch, jump, jalr, a_src_pc  out  1 each  registered control
- result_src  out  RESSRC_W  00 ALU, 01 memory, 10 PC+4
- imm_src  out  IMMSRC_W  000 I, 001 S, 010 B, 011 U, 100 J
- alu_ctrl  out  ALUCTRL_W  see encoding
- rd, rs1, rs2  out  5 each  registered register fields
- illegal  out  1  registered instruction is undecodable

Behaviour:
- Reset (rst=0, async): every output register 0, out_valid=0.
- Pipeline advance: adv = out_ready | ~out_valid.
- Load-use hazard: haz = out_valid & result_src==01 & rd!=0 & (rd==instr[19:15] | rd==instr[24:20]) & in_valid.
- in_ready = adv & ~haz (combinational).
- Clock edge, in priority order:
  - flush=1: out_valid<=0; instr discarded.
  - adv & haz: bubble loaded (out_valid<=0, all control 0).
  - adv & in_valid: decoded fields loaded, out_valid<=1.
  - adv & ~in_valid: out_valid<=0.
  - ~adv: hold all outputs.
- Latency: 1 cycle from accepted instr to out_valid.
- Output stability: outputs change only on advance, flush or reset.
- Opcode decode:
  - 0110011 R: reg_write.
  - 0010011 I-ALU: reg_write, alu_src.
  - 0000011 load: reg_write, alu_src, result_src=01, alu add.
  - 0100011 store: mem_write, alu_src, imm_src=001, alu add.
  - 1100011 branch: branch, imm_src=010, alu sub.
  - 1101111 jal: jump, reg_write, imm_src=100, result_src=10.
  - 1100111 jalr: jalr, reg_write, alu_src, result_src=10, alu add.
  - 0110111 lui: reg_write, alu_src, imm_src=011, alu passB.
  - 0010111 auipc: reg_write, alu_src, a_src_pc, imm_src=011, alu add.
- alu_ctrl encoding (zero-extended to ALUCTRL_W): add 0000, sub 0001, or 0010, and 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001, passB 1010.
- R/I funct3 map: 000 add (sub if R and funct7=0100000), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (sra if funct7=0100000), 110 or, 111 and.
- Illegal instruction, any of:
  - unlisted opcode;
  - R-type funct7 not in {0000000, 0100000};
  - funct7=0100000 on R-type with funct3 not in {000, 101};
  - I-type shift (funct3 001/101) with bad funct7;
  - jalr funct3!=000.
- Illegal handling: illegal=1, out_valid=1, reg_write=mem_write=branch=jump=jalr=0.
- rd/rs1/rs2 registered from instr[11:7], [19:15], [24:20] regardless of type.
- rd=0 never triggers a hazard.

Optional Feature:
- Macro CTRL_DECODE_MEXT_EN.
- Defined: R-type funct7=0000001 is legal; alu_ctrl = {1, funct3} for MUL..REMU. Requires ALUCTRL_W>=4; codes 1000–1111 are then shared by mnemonic space as MEXT_OP with mext=1 output bit added.
- Undefined: funct7=0000001 flagged illegal; no mext port.

Test Plan:
- Reset: rst=0 mid-stream with out_valid=1 -> all outputs 0 immediately (no clock edge needed).
- Decode: instr=0x40B50533 (sub a0,a0,a1) -> next cycle out_valid=1, reg_write=1, alu_ctrl=0001, rd=10.
- Load-use: lw x5,0(x1) accepted, then add x6,x5,x2 -> in_ready=0 for one cycle, bubble with out_valid=0, add issued the following cycle.
- Backpressure: out_ready=0 for 3 cycles with instr 0x00C58593 presented -> outputs held, in_ready=0; accepted on the first cycle out_ready=1.
- Flush: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0, instr not issued.
- Illegal: instr=0x0000007F -> illegal=1, reg_write=0, mem_write=0, out_valid=1.
